layer_sequencer: RTL
====================

# layer_sequencer

- FSM controller that sequences one fully-connected neuron layer on the shared floating-point datapath: input RAM, weight ROM, multiplier, accumulator adder, bias ROM, and the exp/add/div activation chain.
- Replaces free-running magic-count control with explicit states and handshakes.
- Flow: loads an N_INPUTS-word input vector from an AXI-Stream-style source, then for each of N_NEURONS neurons issues the MAC address/strobe sequence, bias lookup and activation start, and presents one result per neuron downstream.
- Emits addresses, enables and strobes only; the datapath carries all data.

## Interface
- N_INPUTS, 784, input vector length (≥2)
- N_NEURONS, 50, neurons per layer (≥1)
- IN_AW, 10, input RAM address width
- W_AW, 16, weight ROM address width; must satisfy 2^W_AW ≥ N_INPUTS·N_NEURONS
- B_AW, 6, bias ROM address width
- MAC_II, 1, cycles between successive MAC terms (1..16)

Ports (name, direction, width, meaning):
- clk in 1 — single clock; all logic on posedge
- rst in 1 — synchronous, active-high reset
- start in 1 — begin a layer pass; sampled only in IDLE
- busy out 1 — high in every state except IDLE
- done out 1 — one-cycle pulse at end of layer
- s_tvalid in 1 / s_tready out 1 — input stream handshake
- in_we out 1, in_waddr out IN_AW — input RAM write port
- in_raddr out IN_AW — input RAM read address
- w_en out 1, w_addr out W_AW — weight ROM
- mac_valid out 1, mac_first out 1, mac_last out 1 — MAC term strobe, accumulator clear, last term
- acc_valid in 1 — accumulator final sum ready
- b_en out 1, b_addr out B_AW — bias ROM
- act_valid out 1 — one-cycle start of bias-add + activation
- act_done in 1 — activation result valid
- m_tvalid out 1, m_tlast out 1, m_tready in 1 — result handshake
- neuron_idx out B_AW — current neuron

## Operation
- States: IDLE → LOAD → MAC → WAIT_ACC → BIAS → WAIT_ACT → OUT → (MAC | DONE) → IDLE.
- IDLE: start → LOAD; clears load, term and neuron counters.
- LOAD:
  - s_tready=1.
  - Each cycle with s_tvalid&&s_tready: in_we=1, in_waddr=beat index.
  - After beat N_INPUTS−1 is accepted → MAC. s_tready is 0 from the next cycle on.
- MAC:
  - Issues term k=0..N_INPUTS−1, one every MAC_II cycles.
  - Per term: in_raddr=k, w_addr=neuron·N_INPUTS+k, w_en=1.
  - w_addr comes from a running counter; no multiplier.
  - After the last issue → WAIT_ACC.
- WAIT_ACC: waits for acc_valid. acc_valid in any other state is ignored.
- BIAS: b_en=1, b_addr=neuron_idx for one cycle. act_valid pulses the following cycle, then → WAIT_ACT.
- WAIT_ACT: act_done → OUT.
- OUT:
  - m_tvalid=1, held until m_tready.
  - m_tlast=1 when neuron_idx=N_NEURONS−1.
  - On handshake: if not last, neuron_idx+1 → MAC (term counter cleared); else → DONE.
- DONE: done=1 for one cycle → IDLE. The input vector stays in RAM but is not reused.
- start while busy is ignored.
- s_tvalid outside LOAD is not accepted and produces no write.

## Timing
- Reset: state IDLE; every output 0, including s_tready, w_en, b_en, m_tvalid, done, all addresses and neuron_idx; counters 0.
- rst mid-operation: the next cycle matches the reset state. Partial results are discarded and no done is emitted.
- Memory read latency is 1 cycle:
  - mac_valid, mac_first and mac_last are delayed one cycle from their address issue.
  - mac_first marks term 0; mac_last marks term N_INPUTS−1.
- With MAC_II=1, mac_valid is continuous for N_INPUTS cycles.
- Minimum per-neuron latency: N_INPUTS·MAC_II + 1 + t_acc + 2 + t_act + 1 cycles. t_acc and t_act are the datapath response delays.
- LOAD with continuous s_tvalid takes exactly N_INPUTS cycles.
- Exactly one act_valid per neuron; exactly N_NEURONS output handshakes per pass.
- Counter wrap: in_raddr returns to 0 for each neuron; w_addr is monotonic across the whole pass.

## Configuration
- LAYER_SEQ_PERF_CNT_EN defined:
  - Adds output perf_cycles [31:0].
  - Cleared on the cycle start is accepted; increments every busy cycle; frozen on done until the next start.
  - Saturates at 0xFFFFFFFF; reset value 0.
- LAYER_SEQ_PERF_CNT_EN undefined: port and counter are absent.

## Test plan
- N_INPUTS=4, N_NEURONS=3, MAC_II=1, continuous input, acc_valid/act_done 3 cycles after their triggers, m_tready=1 →
  - in_waddr 0..3, with s_tready low after the 4th beat;
  - w_addr 0–3, 4–7, 8–11 and b_addr 0,1,2;
  - m_tlast only on the 3rd output;
  - done pulses one cycle after the 3rd handshake.
- Same config, m_tready low for 10 cycles at neuron 0 → m_tvalid held 10 cycles; no mac_valid until the handshake; neuron_idx stays 0.
- s_tvalid alternating 1/0 during LOAD → only accepted beats are written; in_waddr 0..3 over 8 cycles.
- MAC_II=3 → 4 mac_valid pulses spaced 3 cycles; mac_first on the 1st, mac_last on the 4th.
- rst asserted during MAC of neuron 1 → all outputs 0 next cycle. A new start then loads from beat 0 and issues w_addr from 0.
- LAYER_SEQ_PERF_CNT_EN with test 1 config; also start pulsed while busy → perf_cycles equals the busy-cycle count; the second start has no effect.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: control FSM for one fully-connected layer pass on the
// shared floating-point datapath. Emits addresses, enables and strobes only.
// Optional build macro LAYER_SEQ_PERF_CNT_EN adds the perf_cycles counter port.
module layer_sequencer #(
   parameter int N_INPUTS  = 784,
   parameter int N_NEURONS = 50,
   parameter int IN_AW     = 10,
   parameter int W_AW      = 16,
   parameter int B_AW      = 6,
   parameter int MAC_II    = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             s_tvalid,
   output logic             s_tready,
   output logic             in_we,
   output logic [IN_AW-1:0] in_waddr,
   output logic [IN_AW-1:0] in_raddr,
   output logic             w_en,
   output logic [W_AW-1:0]  w_addr,
   output logic             mac_valid,
   output logic             mac_first,
   output logic             mac_last,
   input  logic             acc_valid,
   output logic             b_en,
   output logic [B_AW-1:0]  b_addr,
   output logic             act_valid,
   input  logic             act_done,
   output logic             m_tvalid,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic [B_AW-1:0]  neuron_idx
`ifdef LAYER_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]      perf_cycles
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_MAC, S_WAIT_ACC, S_BIAS, S_WAIT_ACT, S_OUT, S_DONE
   } state_t;

   localparam logic [IN_AW-1:0] LAST_K = IN_AW'(N_INPUTS - 1);
   localparam logic [B_AW-1:0]  LAST_N = B_AW'(N_NEURONS - 1);
   localparam logic [3:0]       II_MAX = 4'(MAC_II - 1);

   state_t           state, state_nxt;
   logic [IN_AW-1:0] ld_cnt;    // input beat index
   logic [IN_AW-1:0] term_cnt;  // MAC term index k within the neuron
   logic [W_AW-1:0]  w_cnt;     // running weight address, monotonic over the pass
   logic [B_AW-1:0]  n_cnt;     // current neuron
   logic [3:0]       ii_cnt;    // spacing between MAC issues
   logic [2:0]       vld_pipe;  // {last, first, valid}, one cycle behind the issue
   logic             act_q;     // act_valid follows the bias lookup by one cycle
   logic             beat, issue, hs, last_term;

   // Next-state logic and all strobes/addresses decoded from state and counters
   always_comb begin
      state_nxt  = state;
      beat       = (state == S_LOAD) && s_tvalid;
      issue      = (state == S_MAC) && (ii_cnt == 4'd0);
      last_term  = (term_cnt == LAST_K);
      hs         = (state == S_OUT) && m_tready;
      busy       = (state != S_IDLE);
      done       = (state == S_DONE);
      s_tready   = (state == S_LOAD);
      in_we      = beat;
      in_waddr   = beat ? ld_cnt : '0;
      in_raddr   = issue ? term_cnt : '0;
      w_en       = issue;
      w_addr     = w_cnt;
      b_en       = (state == S_BIAS);
      b_addr     = n_cnt;
      act_valid  = act_q;
      m_tvalid   = (state == S_OUT);
      m_tlast    = (state == S_OUT) && (n_cnt == LAST_N);
      neuron_idx = n_cnt;
      mac_valid  = vld_pipe[0];
      mac_first  = vld_pipe[1];
      mac_last   = vld_pipe[2];
      case (state)
         S_IDLE:     if (start) state_nxt = S_LOAD;
         S_LOAD:     if (beat && (ld_cnt == LAST_K)) state_nxt = S_MAC;
         S_MAC:      if (issue && last_term) state_nxt = S_WAIT_ACC;
         S_WAIT_ACC: if (acc_valid) state_nxt = S_BIAS;
         S_BIAS:     state_nxt = S_WAIT_ACT;
         S_WAIT_ACT: if (act_done) state_nxt = S_OUT;
         S_OUT:      if (hs) state_nxt = (n_cnt == LAST_N) ? S_DONE : S_MAC;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // State register, counters and the one-cycle read-latency strobe pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ld_cnt   <= '0;
         term_cnt <= '0;
         w_cnt    <= '0;
         n_cnt    <= '0;
         ii_cnt   <= '0;
         vld_pipe <= '0;
         act_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         vld_pipe <= {issue && last_term, issue && (term_cnt == '0), issue};
         act_q    <= (state == S_BIAS);
         case (state)
            S_IDLE: if (start) begin
               ld_cnt   <= '0;
               term_cnt <= '0;
               w_cnt    <= '0;
               n_cnt    <= '0;
               ii_cnt   <= '0;
            end
            S_LOAD: if (beat) ld_cnt <= ld_cnt + 1'b1;
            S_MAC: begin
               ii_cnt <= (ii_cnt == II_MAX) ? 4'd0 : ii_cnt + 4'd1;
               if (issue) begin
                  w_cnt <= w_cnt + 1'b1;
                  if (last_term) begin
                     term_cnt <= '0;
                     ii_cnt   <= '0;
                  end else begin
                     term_cnt <= term_cnt + 1'b1;
                  end
               end
            end
            S_OUT: if (hs && (n_cnt != LAST_N)) begin
               n_cnt    <= n_cnt + 1'b1;
               term_cnt <= '0;
               ii_cnt   <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef LAYER_SEQ_PERF_CNT_EN
   // Busy-cycle counter: cleared on accepted start, saturating, idle-frozen
   always_ff @(posedge clk) begin
      if (rst)
         perf_cycles <= '0;
      else if ((state == S_IDLE) && start)
         perf_cycles <= '0;
      else if ((state != S_IDLE) && (perf_cycles != 32'hFFFF_FFFF))
         perf_cycles <= perf_cycles + 32'd1;
   end
`endif

endmodule
